// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM state type and round-robin pick function for the
// 8-requester mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned WIDTH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] index;
    } pick_t;

    // First eligible index searching ptr, ptr+1, ... with modulo-N wrap.
    function automatic pick_t rr_pick(input logic [N-1:0]     elig,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            r;
        logic [SEL_W-1:0] idx;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr + SEL_W'(i);
            if (!r.valid && elig[idx]) begin
                r.valid = 1'b1;
                r.index = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// Existing 8:1 multiplexer, WIDTH bits per input.
module mux8_4b #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] Y
);

    always_comb begin
        Y = '0;
        unique case (S)
            3'd0: Y = D0;
            3'd1: Y = D1;
            3'd2: Y = D2;
            3'd3: Y = D3;
            3'd4: Y = D4;
            3'd5: Y = D5;
            3'd6: Y = D6;
            3'd7: Y = D7;
            default: Y = '0;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving a shared 8:1 mux into a registered
// valid/ready output slot.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       mask,
    input  logic [N*WIDTH-1:0] d_flat,
    output logic [N-1:0]       gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel_q;
    logic [N-1:0]     elig;
    pick_t            pick;
    logic             slot_open;
    logic             grant;
    logic [WIDTH-1:0] y;

    assign out_valid = (state == FULL);

    always_comb begin
        elig      = req & ~mask;
        pick      = rr_pick(elig, ptr);
        slot_open = (state == EMPTY) || out_ready;
        grant     = rst_n && slot_open && pick.valid;
        gnt       = '0;
        if (grant) begin
            gnt[pick.index] = 1'b1;
        end
        // sel tracks the winner even while the slot is closed; held when idle.
        if (!rst_n) begin
            sel = '0;
        end else if (pick.valid) begin
            sel = pick.index;
        end else begin
            sel = sel_q;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (grant) state_nxt = FULL;
            FULL:  if (out_ready && !grant) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    mux8_4b #(
        .WIDTH(WIDTH)
    ) u_mux (
        .D0(d_flat[0*WIDTH +: WIDTH]),
        .D1(d_flat[1*WIDTH +: WIDTH]),
        .D2(d_flat[2*WIDTH +: WIDTH]),
        .D3(d_flat[3*WIDTH +: WIDTH]),
        .D4(d_flat[4*WIDTH +: WIDTH]),
        .D5(d_flat[5*WIDTH +: WIDTH]),
        .D6(d_flat[6*WIDTH +: WIDTH]),
        .D7(d_flat[7*WIDTH +: WIDTH]),
        .S (sel),
        .Y (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= '0;
            sel_q    <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else begin
            state <= state_nxt;
            sel_q <= sel;
            if (grant) begin
                out_data <= y;
                out_src  <= pick.index;
                ptr      <= pick.index + SEL_W'(1);
            end
        end
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8-to-1, 4-bit multiplexer between eight requesters. Each cycle it chooses one pending requester, drives the mux select with that requester's index, and captures the selected 4-bit word into a registered output. The output uses a valid/ready handshake, so the block sits between eight independent data sources and a single downstream consumer that can apply backpressure.

## Interface
- WIDTH, 4, data width per requester; equals the mux data width.
- N, 8, requester count; fixed at 8 because the mux is 8:1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  8  req[i] high means requester i has a word on d_flat.
- mask  in  8  mask[i] high removes requester i from arbitration.
- d_flat  in  32  requester data; requester i occupies bits [4i+3:4i].
- gnt  out  8  one-hot, combinational; gnt[i] high consumes requester i's word at this edge.
- sel  out  3  mux select, equal to the current winner index (combinational).
- out_valid  out  1  out_data and out_src hold a word.
- out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high.
- out_data  out  4  captured word.
- out_src  out  3  index of the requester that supplied out_data.

## Operation
- Eligible requesters: elig = req & ~mask.
- Round-robin pointer ptr (3 bits) marks the highest-priority index.
  - Search order is ptr, ptr+1, …, 7, 0, …, ptr-1.
  - Wrap-around is modulo 8.
- Winner w is the first eligible index in search order.
- sel = w when elig is non-zero; otherwise sel holds its last value (no glitching when idle).
- The capture slot is open when out_valid is 0, or when out_valid and out_ready are both 1 (simultaneous drain and refill).
- When the slot is open and elig is non-zero:
  - gnt[w] = 1.
  - At the edge: out_data takes the mux output Y, out_src takes w, out_valid becomes 1, and ptr becomes (w+1) mod 8.
  - w=7 sets ptr to 0.
- When the slot is open and elig is zero:
  - gnt = 0.
  - At the edge: out_valid becomes 0 if the current word was drained; otherwise it stays 0.
- When the slot is closed (out_valid=1, out_ready=0):
  - gnt = 0.
  - out_data, out_src and ptr hold.
- Requesters may drop req without a grant. Arbitration is recomputed every cycle and nothing is latched until a grant is issued.
- Masking a requester while its word sits in the output register does not affect that word.
- State machine:
  - EMPTY to FULL: on a grant.
  - FULL to FULL: on a grant with drain, or on a stall.
  - FULL to EMPTY: on a drain with no eligible requester.
  - out_valid equals (state == FULL).

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, state EMPTY.
- gnt=0 and sel=0 while rst_n is low.
- Latency: a word granted at edge k is presented on out_data after edge k. One-cycle latency.
- Throughput: one word per cycle when out_ready is held high and elig is non-zero.
- Fairness: with all 8 requesters continuously eligible and no stalls, each requester is granted exactly once in any 8 consecutive grants.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous).
  - The word in the output register is discarded.
  - ptr returns to 0.
- gnt depends combinationally on req, mask, out_valid, out_ready and ptr.
  - Requesters must not drive req combinationally from gnt (no loop).

## Structure
- Shared package mux8_arb_pkg holds:
  - Constants N=8, SEL_W=3, WIDTH=4.
  - The state enum {EMPTY, FULL}.
  - The round-robin priority-select function (elig, ptr) returning (valid, index).
- The existing 4-bit 8:1 multiplexer is instantiated once as a sub-module.
  - D0..D7 are wired from the d_flat slices; S is driven by sel.
  - No second copy of the data path is written.

## Test plan
- Reset: drive d_flat with D_i = i+1 and all req=0. Release rst_n → out_valid=0, gnt=0, out_data=0, out_src=0.
- Full rotation: req=8'hFF, mask=0, out_ready=1, D_i = i+1.
  - out_src sequence must be 0,1,2,…,7,0 on consecutive cycles.
  - out_data sequence must be 1,2,…,8,1.
  - Exactly one gnt bit is high per cycle.
- Backpressure: requester 3 granted (out_data=4), then out_ready=0 for 5 cycles.
  - out_data stays 4 and gnt=0 throughout.
  - On the cycle out_ready returns to 1, the next eligible requester is granted and captured on the same edge.
- Wrap and skip: ptr=6 and req=8'b0000_0101 → grant order 0 then 2, with ptr ending at 3.
  - Then req=8'h80 only → out_src=7 and ptr wraps to 0.
- Mask: req=8'hFF, mask=8'hF0 → only sources 0–3 ever appear on out_src.
  - Then mask=8'hFF → out_valid falls to 0 after the current word drains.
- Asynchronous reset mid-stream: pull rst_n low between edges while out_valid=1 and out_data=5.
  - out_valid=0 immediately, without waiting for an edge.
  - After release with req=8'hFF, the first out_src is 0.
